// File: rtl/wdomain_rptr_rx.sv
// Write-domain receiver for the async FIFO Gray read pointer: CDC sync, decode, level/free, almost-full, error checks.
// Optional peak-occupancy tracker enabled by defining WLEVEL_PEAK_EN.
module wdomain_rptr_rx #(
    parameter int unsigned PTR_WIDTH    = 3,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                 w_clk,
    input  logic                 wrst_n,
    input  logic [PTR_WIDTH:0]   g_rptr_async,
    input  logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_rptr_sync,
    output logic [PTR_WIDTH:0]   b_rptr_sync,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic [PTR_WIDTH:0]   wr_free,
    output logic                 almost_full,
    output logic                 sync_ready,
    output logic                 ptr_err
`ifdef WLEVEL_PEAK_EN
    ,
    input  logic                 peak_clr,
    output logic [PTR_WIDTH:0]   wr_peak
`endif
);

    localparam int unsigned PW         = PTR_WIDTH + 1;
    localparam int unsigned DEPTH      = 1 << PTR_WIDTH;
    localparam int unsigned FLUSH_LAST = SYNC_STAGES + 1;
    localparam int unsigned CNT_W      = $clog2(FLUSH_LAST + 1);

    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] THRESH_P = PW'(AFULL_THRESH);

    typedef enum logic {
        S_FLUSH = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sync_ready;
    logic             w_afull;

    logic [PW-1:0] r_sync [SYNC_STAGES];
    logic [PW-1:0] r_g_prev;
    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_level;
    logic          r_err;

    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_raw;
    logic          w_over;
    logic [PW-1:0] w_level_nxt;
    logic [PW-1:0] w_gdiff;
    logic          w_multi;

    // Plain flop chain: no logic allowed between CDC stages
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= g_rptr_async;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign g_rptr_sync = r_sync[SYNC_STAGES-1];

    // Gray to binary: running XOR from the MSB down
    always_comb begin
        logic acc;
        w_bin = '0;
        acc   = 1'b0;
        for (int i = int'(PTR_WIDTH); i >= 0; i--) begin
            acc      = acc ^ g_rptr_sync[i];
            w_bin[i] = acc;
        end
    end

    assign w_raw       = b_wptr - r_bin;
    assign w_over      = (w_raw > DEPTH_P);
    assign w_level_nxt = w_over ? DEPTH_P : w_raw;
    assign w_gdiff     = g_rptr_sync ^ r_g_prev;
    assign w_multi     = |(w_gdiff & (w_gdiff - PW'(1)));

    // FSM state register
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state <= S_FLUSH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FLUSH holds outputs safe until the sync chain and decode stage have refilled
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sync_ready = 1'b0;
        w_afull      = 1'b1;
        case (r_state)
            S_FLUSH: begin
                if (r_cnt == CNT_W'(FLUSH_LAST)) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                w_sync_ready = 1'b1;
                w_afull      = (r_level >= THRESH_P);
            end
            default: begin
                w_state_nxt = S_FLUSH;
            end
        endcase
    end

    // Decode, level and sticky error registers
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_g_prev <= '0;
            r_bin    <= '0;
            r_level  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_g_prev <= g_rptr_sync;
            r_bin    <= w_bin;
            r_level  <= w_level_nxt;
            if (w_sync_ready && (w_multi || w_over)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign b_rptr_sync = r_bin;
    assign wr_level    = r_level;
    assign wr_free     = DEPTH_P - r_level;
    assign almost_full = w_afull;
    assign sync_ready  = w_sync_ready;
    assign ptr_err     = r_err;

`ifdef WLEVEL_PEAK_EN
    logic [PW-1:0] r_peak;

    // Clear reloads the current level; otherwise track the maximum while running
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_peak <= '0;
        end else if (peak_clr) begin
            r_peak <= r_level;
        end else if (w_sync_ready && (r_level > r_peak)) begin
            r_peak <= r_level;
        end
    end

    assign wr_peak = r_peak;
`endif

endmodule

// File: tb/tb_wdomain_rptr_rx.sv
// Scoreboard bench for wdomain_rptr_rx (PTR_WIDTH=3, SYNC_STAGES=2, AFULL_THRESH=6).
// Driver queues expected values tagged with a cycle number; a negedge monitor checks them.
module tb_wdomain_rptr_rx;

    logic       w_clk;
    logic       wrst_n;
    logic [3:0] g_rptr_async;
    logic [3:0] b_wptr;
    logic [3:0] g_rptr_sync;
    logic [3:0] b_rptr_sync;
    logic [3:0] wr_level;
    logic [3:0] wr_free;
    logic       almost_full;
    logic       sync_ready;
    logic       ptr_err;
`ifdef WLEVEL_PEAK_EN
    logic       peak_clr;
    logic [3:0] wr_peak;
`endif

    wdomain_rptr_rx #(
        .PTR_WIDTH    (3),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (6)
    ) dut (
        .w_clk        (w_clk),
        .wrst_n       (wrst_n),
        .g_rptr_async (g_rptr_async),
        .b_wptr       (b_wptr),
        .g_rptr_sync  (g_rptr_sync),
        .b_rptr_sync  (b_rptr_sync),
        .wr_level     (wr_level),
        .wr_free      (wr_free),
        .almost_full  (almost_full),
        .sync_ready   (sync_ready),
        .ptr_err      (ptr_err)
`ifdef WLEVEL_PEAK_EN
        ,
        .peak_clr     (peak_clr),
        .wr_peak      (wr_peak)
`endif
    );

    typedef enum int {F_GSYNC, F_BSYNC, F_LEVEL, F_FREE, F_AF, F_SR, F_ERR, F_PEAK} field_e;

    typedef struct {
        int         cyc;
        field_e     fld;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    always @(posedge w_clk) cyc <= cyc + 1;

    function automatic logic [3:0] dut_val(input field_e f);
        case (f)
            F_GSYNC: return g_rptr_sync;
            F_BSYNC: return b_rptr_sync;
            F_LEVEL: return wr_level;
            F_FREE:  return wr_free;
            F_AF:    return {3'b000, almost_full};
            F_SR:    return {3'b000, sync_ready};
            F_ERR:   return {3'b000, ptr_err};
`ifdef WLEVEL_PEAK_EN
            F_PEAK:  return wr_peak;
`endif
            default: return 4'bxxxx;
        endcase
    endfunction

    // Monitor: compare every entry due in the current cycle
    always @(negedge w_clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [3:0] act;
                act = dut_val(sb[i].fld);
                n_checks++;
                if (sb[i].cyc < cyc || act !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d (due %0d): got %0d, expected %0d",
                             sb[i].name, cyc, sb[i].cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int d, input field_e f, input logic [3:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + d;
        e.fld  = f;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge w_clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_vals();
        expect_at(0, F_SR,    4'd0, "rst_sync_ready");
        expect_at(0, F_AF,    4'd1, "rst_almost_full");
        expect_at(0, F_FREE,  4'd8, "rst_wr_free");
        expect_at(0, F_LEVEL, 4'd0, "rst_wr_level");
        expect_at(0, F_ERR,   4'd0, "rst_ptr_err");
        expect_at(0, F_GSYNC, 4'd0, "rst_g_rptr_sync");
        expect_at(0, F_BSYNC, 4'd0, "rst_b_rptr_sync");
`ifdef WLEVEL_PEAK_EN
        expect_at(0, F_PEAK,  4'd0, "rst_wr_peak");
`endif
    endtask

    // Release reset between edges; FLUSH lasts 4 edges, RUN visible after the 4th
    task automatic release_and_flush();
        @(negedge w_clk);
        #1 wrst_n = 1'b1;
        for (int d = 1; d <= 3; d++) begin
            expect_at(d, F_SR,   4'd0, "flush_sync_ready");
            expect_at(d, F_AF,   4'd1, "flush_almost_full");
            expect_at(d, F_FREE, 4'd8, "flush_wr_free");
        end
        expect_at(4, F_SR,    4'd1, "run_sync_ready");
        expect_at(4, F_AF,    4'd0, "run_almost_full");
        expect_at(4, F_LEVEL, 4'd0, "run_wr_level");
        steps(4);
    endtask

    logic [3:0] ramp_lvl  [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    logic [3:0] ramp_free [9] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    logic [3:0] ramp_af   [9] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
    logic [3:0] walk_g    [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
    logic [3:0] walk_b    [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    logic [3:0] walk_lvl  [4] = '{4'd8, 4'd7, 4'd6, 4'd5};
    logic [3:0] walk_af   [4] = '{4'd1, 4'd1, 4'd1, 4'd0};

    initial begin
        wrst_n       = 1'b0;
        g_rptr_async = 4'b0000;
        b_wptr       = 4'b0000;
`ifdef WLEVEL_PEAK_EN
        peak_clr     = 1'b0;
`endif
        // Reset values and first flush
        step();
        check_reset_vals();
        release_and_flush();

        // Write pointer ramp 0..8 with read pointer at 0
        for (int k = 0; k < 9; k++) begin
            b_wptr = 4'(k);
            expect_at(1, F_LEVEL, ramp_lvl[k],  "ramp_wr_level");
            expect_at(1, F_FREE,  ramp_free[k], "ramp_wr_free");
            expect_at(1, F_AF,    ramp_af[k],   "ramp_almost_full");
            step();
        end

        // Gray read pointer walk 0,1,2,3 with write pointer at 8
        for (int k = 0; k < 4; k++) begin
            g_rptr_async = walk_g[k];
            expect_at(2, F_GSYNC, walk_g[k],   "walk_g_rptr_sync");
            expect_at(3, F_BSYNC, walk_b[k],   "walk_b_rptr_sync");
            expect_at(4, F_LEVEL, walk_lvl[k], "walk_wr_level");
            expect_at(4, F_AF,    walk_af[k],  "walk_almost_full");
            expect_at(4, F_ERR,   4'd0,        "walk_ptr_err");
            steps(4);
        end

        // Wrap: read pointer 12 (Gray 1010), write pointer 2 once decode lands
        g_rptr_async = 4'b1010;
        expect_at(2, F_GSYNC, 4'b1010, "wrap_g_rptr_sync");
        expect_at(3, F_BSYNC, 4'b1100, "wrap_b_rptr_sync");
        steps(3);
        b_wptr = 4'b0010;
        expect_at(1, F_LEVEL, 4'd6, "wrap_wr_level");
        expect_at(1, F_FREE,  4'd2, "wrap_wr_free");
        expect_at(1, F_AF,    4'd1, "wrap_almost_full");
        expect_at(2, F_ERR,   4'd0, "wrap_ptr_err");
        steps(2);

        // Two-bit Gray jump 1010 -> 1001 flags an error and it sticks
        g_rptr_async = 4'b1001;
        expect_at(2, F_GSYNC, 4'b1001, "jump_g_rptr_sync");
        expect_at(2, F_ERR,   4'd0,    "jump_err_before");
        expect_at(3, F_ERR,   4'd1,    "jump_err_set");
        expect_at(3, F_BSYNC, 4'b1110, "jump_b_rptr_sync");
        steps(4);
        b_wptr = 4'b0011;
        expect_at(1, F_LEVEL, 4'd5, "jump_wr_level");
        expect_at(1, F_ERR,   4'd1, "jump_err_sticky");
        steps(2);

        // Mid-run reset with level 5 and error set
        wrst_n       = 1'b0;
        g_rptr_async = 4'b0000;
        b_wptr       = 4'b0000;
        check_reset_vals();
        release_and_flush();

        // Level 5 then 2, with peak tracking and clear when enabled
        b_wptr = 4'd5;
        expect_at(1, F_LEVEL, 4'd5, "pk_wr_level5");
`ifdef WLEVEL_PEAK_EN
        expect_at(2, F_PEAK,  4'd5, "pk_track5");
`endif
        steps(2);
        b_wptr = 4'd2;
        expect_at(1, F_LEVEL, 4'd2, "pk_wr_level2");
        expect_at(1, F_AF,    4'd0, "pk_almost_full");
`ifdef WLEVEL_PEAK_EN
        expect_at(1, F_PEAK,  4'd5, "pk_hold5");
`endif
        step();
`ifdef WLEVEL_PEAK_EN
        peak_clr = 1'b1;
        expect_at(1, F_PEAK, 4'd2, "pk_clear");
`endif
        step();
`ifdef WLEVEL_PEAK_EN
        peak_clr = 1'b0;
        expect_at(2, F_PEAK, 4'd2, "pk_after_clear");
`endif
        b_wptr = 4'd0;
        expect_at(1, F_LEVEL, 4'd0, "pk_wr_level0");
        steps(2);

        // Overrun: write pointer 10 ahead of read pointer 0 clamps and flags
        expect_at(0, F_ERR, 4'd0, "ovr_err_before");
        b_wptr = 4'b1010;
        expect_at(1, F_LEVEL, 4'd8, "ovr_wr_level_clamp");
        expect_at(1, F_FREE,  4'd0, "ovr_wr_free");
        expect_at(1, F_ERR,   4'd1, "ovr_err_set");
        expect_at(3, F_ERR,   4'd1, "ovr_err_sticky");
        steps(5);

        if (sb.size() != 0) begin
            n_fail += sb.size();
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
